prog_loader: RTL and testbench

Parametrised program loader and run sequencer for the pipelined TinyRISC core. It accepts a big-endian byte stream over a valid/ready handshake and packs it into 32-bit words written to the core's instruction memory. While loading it holds the core in reset, then releases it for a bounded run. It reports completion on a core halt or on a cycle budget, replacing hand-poked instruction memory and fixed-delay reset sequencing.

---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/prog_loader_byte_packer.sv | 68 ++++++
 rtl/prog_loader.sv | 147 ++++++++++++++
 tb/tb_prog_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, word geometry
// and the byte order of the incoming stream.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);
  localparam bit MSB_FIRST      = 1'b1;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs an 8-bit stream into 32-bit words; word_valid pulses for one cycle
// after the last byte of each word is accepted.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [BCNT_W-1:0] byte_cnt,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  localparam int PART_W = WORD_W - BYTE_W;

  logic [BCNT_W-1:0] cnt_reg;
  logic [PART_W-1:0] part_reg;
  logic [PART_W-1:0] part_next;
  logic [WORD_W-1:0] full_word;
  logic [WORD_W-1:0] word_reg;
  logic              word_valid_reg;
  logic              last_byte;

  // Only the first three bytes are kept; the fourth goes straight into the word.
  generate
    if (MSB_FIRST) begin : g_msb
      assign part_next = {part_reg[PART_W-BYTE_W-1:0], byte_data};
      assign full_word = {part_reg, byte_data};
    end else begin : g_lsb
      assign part_next = {byte_data, part_reg[PART_W-1:BYTE_W]};
      assign full_word = {byte_data, part_reg};
    end
  endgenerate

  assign last_byte = (cnt_reg == BCNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      part_reg       <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
    end else if (clr) begin
      cnt_reg        <= '0;
      part_reg       <= '0;
      word_valid_reg <= 1'b0;
    end else begin
      word_valid_reg <= 1'b0;
      if (byte_valid) begin
        part_reg <= part_next;
        if (last_byte) begin
          cnt_reg        <= '0;
          word_reg       <= full_word;
          word_valid_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign byte_cnt   = cnt_reg;
  assign word       = word_reg;
  assign word_valid = word_valid_reg;

endmodule

// File: rtl/prog_loader.sv
// Program loader and run sequencer: streams bytes into instruction memory while
// holding the core in reset, then releases it for a bounded run.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = 8,
  parameter int RST_HOLD   = 2,
  parameter int RUN_MAX    = 200
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(IMEM_DEPTH+1)-1:0]  len_words,
  input  logic                             in_valid,
  input  logic [7:0]                       in_data,
  output logic                             in_ready,
  input  logic                             halt,
  output logic                             imem_we,
  output logic [ADDR_W-1:0]                imem_addr,
  output logic [31:0]                      imem_wdata,
  output logic                             core_rst,
  output logic                             busy,
  output logic                             done,
  output logic                             timeout,
  output logic                             err,
  output logic [31:0]                      run_cycles
);

  localparam int LEN_W  = $clog2(IMEM_DEPTH + 1);
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_t state_reg, state_next;

  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  word_idx_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [31:0]       run_cycles_reg;
  logic [ADDR_W-1:0] imem_addr_reg;
  logic              in_ready_reg;
  logic              core_rst_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              timeout_reg;
  logic              err_reg;

  logic              idle_or_done;
  logic              len_ok;
  logic              start_ok;
  logic              start_bad;
  logic              byte_fire;
  logic              word_done;
  logic              last_word;
  logic              hold_done;
  logic              run_timeout;
  logic [BCNT_W-1:0] byte_cnt;

  prog_loader_byte_packer u_byte_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ok),
    .byte_valid (byte_fire),
    .byte_data  (in_data),
    .byte_cnt   (byte_cnt),
    .word       (imem_wdata),
    .word_valid (imem_we)
  );

  assign idle_or_done = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign len_ok       = (len_words != '0) && (len_words <= LEN_W'(IMEM_DEPTH));
  assign start_ok     = start && idle_or_done && len_ok;
  assign start_bad    = start && idle_or_done && !len_ok;
  assign byte_fire    = in_valid && in_ready_reg;
  assign word_done    = byte_fire && (byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));
  assign last_word    = word_done && (word_idx_reg == len_reg - 1'b1);
  assign hold_done    = (hold_cnt_reg == HOLD_W'(RST_HOLD - 1));
  assign run_timeout  = (run_cycles_reg == 32'(RUN_MAX - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (start_ok)            state_next = S_LOAD;
      S_LOAD:         if (last_word)           state_next = S_RELEASE;
      S_RELEASE:      if (hold_done)           state_next = S_RUN;
      S_RUN:          if (halt || run_timeout) state_next = S_DONE;
      default:                                 state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      len_reg        <= '0;
      word_idx_reg   <= '0;
      hold_cnt_reg   <= '0;
      run_cycles_reg <= '0;
      imem_addr_reg  <= '0;
      in_ready_reg   <= 1'b0;
      core_rst_reg   <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg    <= state_next;
      // Status outputs are registered copies of the next state.
      in_ready_reg <= (state_next == S_LOAD);
      busy_reg     <= (state_next == S_LOAD) || (state_next == S_RELEASE) ||
                      (state_next == S_RUN);
      core_rst_reg <= (state_next != S_RUN);
      done_reg     <= (state_next == S_DONE);
      err_reg      <= start_bad;

      if (start_ok) begin
        len_reg        <= len_words;
        word_idx_reg   <= '0;
        run_cycles_reg <= '0;
        timeout_reg    <= 1'b0;
      end

      if (word_done) begin
        imem_addr_reg <= ADDR_W'({word_idx_reg, 2'b00});
        word_idx_reg  <= word_idx_reg + 1'b1;
      end

      if (state_reg == S_RELEASE) hold_cnt_reg <= hold_cnt_reg + 1'b1;
      else                        hold_cnt_reg <= '0;

      // The counter freezes on the exiting cycle; halt takes priority over the budget.
      if (state_reg == S_RUN) begin
        if (halt)             timeout_reg    <= 1'b0;
        else if (run_timeout) timeout_reg    <= 1'b1;
        else                  run_cycles_reg <= run_cycles_reg + 1'b1;
      end
    end
  end

  assign in_ready   = in_ready_reg;
  assign imem_addr  = imem_addr_reg;
  assign core_rst   = core_rst_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign timeout    = timeout_reg;
  assign err        = err_reg;
  assign run_cycles = run_cycles_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: loads push expected writes, a monitor pops
// and compares each imem write; control/status checks are directed.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  len_words;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        halt;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        err;
  logic [31:0] run_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  logic [39:0] exp_q[$];

  logic [31:0] prog [7] = '{32'h4C400011, 32'h4C800010, 32'h00000013, 32'h12345678,
                            32'hDEADBEEF, 32'hA5A5005A, 32'h4CC00001};

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len_words  (len_words),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .halt       (halt),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .err        (err),
    .run_cycles (run_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          $display("write addr=%h data=%h (expected %h/%h)", imem_addr, imem_wdata, e[39:32], e[31:0]);
          check("write_addr", {24'h0, imem_addr}, {24'h0, e[39:32]});
          check("write_data", imem_wdata, e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_in_ready"},   in_ready,   0);
    check({tag, "_imem_we"},    imem_we,    0);
    check({tag, "_imem_addr"},  imem_addr,  0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_core_rst"},   core_rst,   1);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_done"},       done,       0);
    check({tag, "_timeout"},    timeout,    0);
    check({tag, "_err"},        err,        0);
    check({tag, "_run_cycles"}, run_cycles, 0);
  endtask

  task automatic do_start(input int len);
    start     = 1'b1;
    len_words = 7'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], max_gap);
  endtask

  task automatic load_prog(input int n, input int max_gap);
    do_start(n);
    for (int i = 0; i < n; i++) exp_q.push_back({8'(i * 4), prog[i]});
    for (int i = 0; i < n; i++) send_word(prog[i], max_gap);
  endtask

  initial begin
    int base;
    int n;
    int run_cnt;
    bit found;

    rst = 1'b1; start = 1'b0; len_words = '0;
    in_valid = 1'b0; in_data = '0; halt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Gap-free 7-word load, reset-release timing and halt on RUN cycle 40.
    base = wr_count;
    load_prog(7, 0);
    @(negedge clk); check("release1_core_rst", core_rst, 1);
    @(negedge clk); check("release2_core_rst", core_rst, 1);
    @(negedge clk); check("run0_core_rst", core_rst, 0);
    check("run0_busy", busy, 1);
    check("load1_writes", wr_count - base, 7);
    check("load1_queue_empty", exp_q.size(), 0);
    found = 1'b0;
    for (n = 0; n < 100; n++) begin
      if (run_cycles == 40) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("halt_wait", found, 1);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check("halt_done", done, 1);
    check("halt_timeout", timeout, 0);
    check("halt_run_cycles", run_cycles, 40);
    check("halt_core_rst", core_rst, 1);
    check("halt_busy", busy, 0);

    // Same program with random valid gaps, then run to the cycle budget.
    base = wr_count;
    load_prog(7, 3);
    run_cnt = 0;
    found = 1'b0;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done) begin found = 1'b1; break; end
      if (!core_rst) run_cnt++;
    end
    check("budget_wait", found, 1);
    check("budget_run_len", run_cnt, 200);
    check("budget_timeout", timeout, 1);
    check("budget_run_cycles", run_cycles, 199);
    check("load2_writes", wr_count - base, 7);
    check("load2_queue_empty", exp_q.size(), 0);

    // Rejected starts from DONE.
    base = wr_count;
    do_start(0);
    @(negedge clk);
    check("len0_err", err, 1);
    check("len0_done_kept", done, 1);
    check("len0_busy", busy, 0);
    @(negedge clk);
    check("len0_err_pulse", err, 0);
    do_start(65);
    @(negedge clk);
    check("len65_err", err, 1);
    check("len65_done_kept", done, 1);
    @(negedge clk);
    check("len65_err_pulse", err, 0);
    check("rejected_no_writes", wr_count - base, 0);

    // Start while busy is ignored; rst after 2 bytes of word 3 discards it.
    base = wr_count;
    do_start(5);
    check("restart_done_clear", done, 0);
    for (int i = 0; i < 3; i++) exp_q.push_back({8'(i * 4), prog[i]});
    send_word(prog[0], 0);
    do_start(2);
    @(negedge clk);
    check("busy_start_err", err, 0);
    check("busy_start_busy", busy, 1);
    check("busy_start_in_ready", in_ready, 1);
    send_word(prog[1], 0);
    send_word(prog[2], 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outs("mid_rst");
    @(negedge clk);
    check("mid_rst_no_write", imem_we, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_writes", wr_count - base, 3);
    check("mid_rst_queue_empty", exp_q.size(), 0);

    // Fresh load restarts at address 0; halt on the very first RUN cycle.
    base = wr_count;
    load_prog(2, 0);
    found = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!core_rst) begin found = 1'b1; break; end
    end
    check("reload_run_wait", found, 1);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check("reload_done", done, 1);
    check("reload_timeout", timeout, 0);
    check("reload_run_cycles", run_cycles, 0);
    check("reload_writes", wr_count - base, 2);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
